deserializer: RTL and testbench

Serial-to-parallel receiver, the receive-side counterpart of the team's MSB-first `serializer`. It samples one bit per flagged cycle into a shift register and publishes the assembled `MSG_SIZE`-bit word with a valid/ack handshake. It exposes a bit counter that reaches exactly `MSG_SIZE` when a word is complete, so `oCounter` can directly drive a `serializer`'s `iCounter` trigger.

---
 rtl/deserializer_pkg.sv | 17 +
 rtl/deserializer_bit_counter.sv | 28 ++
 rtl/deserializer.sv | 118 +++++++++++
 tb/tb_deserializer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial link blocks (deserializer, serializer).
package deserializer_pkg;

    localparam int unsigned MSG_SIZE_DEFAULT = 64;

    // Counter wide enough to hold 0..msg_size inclusive.
    function automatic int unsigned counter_width(input int unsigned msg_size);
        return $clog2(msg_size) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/deserializer_bit_counter.sv
// Saturating up-counter with synchronous clear and load-one; clear wins over load, load over increment.
module bit_counter #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned MAX   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_one,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= WIDTH'(1);
        end else if (inc && (count != MAX_C)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with valid/ack handshake and sticky overrun flag.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int unsigned MSG_SIZE = MSG_SIZE_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ena,
    input  logic                                 iData_in,
    input  logic                                 iData_flag,
    input  logic                                 iAck,
    input  logic                                 iClear,
    output logic [MSG_SIZE-1:0]                  oData_out,
    output logic [counter_width(MSG_SIZE)-1:0]   oCounter,
    output logic                                 oValid,
    output logic                                 oOverrun
);

    localparam int unsigned       CW   = counter_width(MSG_SIZE);
    localparam logic [CW-1:0]     LAST = CW'(MSG_SIZE - 1);

    state_t              state;
    // Only MSG_SIZE-1 bits are stored; the final bit goes straight into oData_out.
    logic [MSG_SIZE-2:0] shift_reg;
    logic [MSG_SIZE-1:0] next_word;
    logic                take_bit;
    logic                cnt_clear;
    logic                cnt_load_one;
    logic                cnt_inc;

    assign next_word = {shift_reg, iData_in};
    assign take_bit  = ena && iData_flag;

    always_comb begin
        cnt_clear    = 1'b0;
        cnt_load_one = 1'b0;
        cnt_inc      = 1'b0;
        if (ena) begin
            if (iClear) begin
                cnt_clear = 1'b1;
            end else begin
                unique case (state)
                    IDLE:    cnt_load_one = iData_flag;
                    SHIFT:   cnt_inc      = iData_flag;
                    FULL: begin
                        cnt_load_one = iAck && iData_flag;
                        cnt_clear    = iAck && !iData_flag;
                    end
                    default: cnt_clear = 1'b1;
                endcase
            end
        end
    end

    bit_counter #(
        .WIDTH (CW),
        .MAX   (MSG_SIZE)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load_one (cnt_load_one),
        .inc      (cnt_inc),
        .count    (oCounter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            oData_out <= '0;
            oValid    <= 1'b0;
            oOverrun  <= 1'b0;
        end else if (ena) begin
            if (iClear) begin
                state     <= IDLE;
                shift_reg <= '0;
                oValid    <= 1'b0;
                oOverrun  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (take_bit) begin
                            shift_reg <= next_word[MSG_SIZE-2:0];
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (take_bit) begin
                            shift_reg <= next_word[MSG_SIZE-2:0];
                            if (oCounter == LAST) begin
                                oData_out <= next_word;
                                oValid    <= 1'b1;
                                state     <= FULL;
                            end
                        end
                    end
                    FULL: begin
                        if (iAck) begin
                            oValid <= 1'b0;
                            if (take_bit) begin
                                shift_reg <= next_word[MSG_SIZE-2:0];
                                state     <= SHIFT;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (take_bit) begin
                            oOverrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (MSG_SIZE = 8): vector table, hand sequences, word scoreboard.
module tb_deserializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         iData_in = 1'b0;
    logic         iData_flag = 1'b0;
    logic         iAck = 1'b0;
    logic         iClear = 1'b0;
    logic [W-1:0] oData_out;
    logic [3:0]   oCounter;
    logic         oValid;
    logic         oOverrun;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb[$];
    logic prev_v = 1'b0;

    typedef struct {
        logic       ena;
        logic       flag;
        logic       d;
        logic       ack;
        logic       clr;
        logic [3:0] cnt;
        logic       valid;
        logic       ovr;
    } vec_t;
    vec_t tbl[10];

    deserializer #(.MSG_SIZE(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .iData_in   (iData_in),
        .iData_flag (iData_flag),
        .iAck       (iAck),
        .iClear     (iClear),
        .oData_out  (oData_out),
        .oCounter   (oCounter),
        .oValid     (oValid),
        .oOverrun   (oOverrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic f, input logic d, input logic a, input logic c);
        ena = e; iData_flag = f; iData_in = d; iAck = a; iClear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        sb.push_back(w);
        for (int i = W - 1; i >= 0; i--) cyc(1'b1, 1'b1, w[i], 1'b0, 1'b0);
        ena = 1'b1; iData_flag = 1'b0;
    endtask

    // Scoreboard: each new rising oValid must present the next expected word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && oValid && !prev_v) begin
                if (sb.size() == 0) begin
                    check("word_unexpected", oData_out, 64'hx);
                end else begin
                    check("word", oData_out, sb.pop_front());
                end
            end
            prev_v = oValid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;

        // Basic word 0xA5, ack in first FULL cycle, then ack while IDLE (no effect).
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tbl[i].ena = 1'b1; tbl[i].flag = 1'b1; tbl[i].d = w[7-i];
            tbl[i].ack = 1'b0; tbl[i].clr = 1'b0;
            tbl[i].cnt = 4'(i + 1); tbl[i].valid = (i == 7); tbl[i].ovr = 1'b0;
        end
        for (int i = 8; i < 10; i++) begin
            tbl[i].ena = 1'b1; tbl[i].flag = 1'b0; tbl[i].d = 1'b0;
            tbl[i].ack = 1'b1; tbl[i].clr = 1'b0;
            tbl[i].cnt = 4'd0; tbl[i].valid = 1'b0; tbl[i].ovr = 1'b0;
        end

        #12;
        check("rst_data", oData_out, 0);
        check("rst_cnt", oCounter, 0);
        check("rst_valid", oValid, 0);
        check("rst_ovr", oOverrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        sb.push_back(8'hA5);
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].ena, tbl[i].flag, tbl[i].d, tbl[i].ack, tbl[i].clr);
            check($sformatf("tbl%0d_cnt", i), oCounter, tbl[i].cnt);
            check($sformatf("tbl%0d_valid", i), oValid, tbl[i].valid);
            check($sformatf("tbl%0d_ovr", i), oOverrun, tbl[i].ovr);
        end
        check("basic_data_held", oData_out, 8'hA5);

        // Gapped 0x3C with random idle gaps and an ena=0 window carrying flag/ack/clear.
        w = 8'h3C;
        sb.push_back(w);
        for (int i = 0; i < 8; i++) begin
            int gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 4) begin
                cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
                cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
                check("gap_ena_low_cnt", oCounter, 4);
            end
            cyc(1'b1, 1'b1, w[7-i], 1'b0, 1'b0);
            check($sformatf("gap_cnt%0d", i), oCounter, i + 1);
        end
        check("gap_valid", oValid, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("gap_ack_cnt", oCounter, 0);

        // Overrun: 0xFF held without ack, three extra flagged bits dropped.
        send_word(8'hFF);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_data", oData_out, 8'hFF);
        check("ovr_cnt", oCounter, 8);
        check("ovr_flag", oOverrun, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_sticky", oOverrun, 1);
        check("ovr_ack_valid", oValid, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", oOverrun, 0);

        // Ack together with first bit of the next word.
        send_word(8'h42);
        w = 8'h81;
        sb.push_back(w);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, w[7-i], (i == 0), 1'b0);
            check($sformatf("af_valid%0d", i), oValid, (i == 7));
            check($sformatf("af_cnt%0d", i), oCounter, i + 1);
        end
        check("af_ovr", oOverrun, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Clear after 5 bits, then a full word.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_cnt", oCounter, 0);
        check("clr_data_kept", oData_out, 8'h81);
        send_word(8'h5A);
        check("clr_word", oData_out, 8'h5A);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after 3 bits.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_data", oData_out, 0);
        check("arst_cnt", oCounter, 0);
        check("arst_valid", oValid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1; iData_flag = 1'b0; iAck = 1'b0; iClear = 1'b0;
        send_word(8'hC3);
        check("post_rst_word_cnt", oCounter, 8);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
